// File: rtl/acc_cpu_sc_if.sv
// Program-load, start handshake and architectural status of the acc_cpu_sc core.
// The host drives the master side; the CPU core implements the slave side.
interface acc_cpu_sc_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              halt;
    logic              busy;
    logic [3:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] acc;
    logic              carry;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        output start, prog_we, prog_addr, prog_data,
        input  halt, busy, state, pc, acc, carry, instr_count
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_data,
        output halt, busy, state, pc, acc, carry, instr_count
    );
endinterface

// File: rtl/acc_cpu_sc.sv
// Single-clock accumulator CPU: 8-phase sequencer, synchronous-read RAM,
// program-load port, carry flag and saturating retired-instruction counter.
module acc_cpu_sc #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input logic         clk,
    input logic         rst,
    acc_cpu_sc_if.slave bus
);
    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_STOPPED    = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3,
        OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7
    } opcode_e;

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    opcode_e           op_q, op_d;
    logic [ADDR_W-1:0] opnd_q, opnd_d;
    logic              carry_q, carry_d;
    logic              halt_q, halt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W:0]   sum;
    logic [CNT_W-1:0]  cnt_inc;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        carry_d   = carry_q;
        halt_d    = halt_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rdata_d   = mem_q[addr_q];
        mem_we    = 1'b0;
        mem_waddr = opnd_q;
        mem_wdata = acc_q;
        sum       = {1'b0, acc_q} + {1'b0, rdata_q};
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            S_STOPPED: begin
                if (bus.prog_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.prog_addr;
                    mem_wdata = bus.prog_data;
                end
                if (bus.start) begin
                    state_d = S_INST_ADDR;
                    halt_d  = 1'b0;
                end
            end
            S_INST_ADDR: begin
                addr_d  = pc_q;
                state_d = S_INST_FETCH;
            end
            S_INST_FETCH: state_d = S_INST_LOAD;
            S_INST_LOAD: begin
                op_d    = opcode_e'(rdata_q[DATA_W-1 -: 3]);
                opnd_d  = rdata_q[ADDR_W-1:0];
                state_d = S_IDLE;
            end
            S_IDLE: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_OP_ADDR;
            end
            S_OP_ADDR: begin
                if (op_q == OP_HLT) begin
                    halt_d  = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = S_STOPPED;
                end else begin
                    addr_d  = opnd_q;
                    state_d = S_OP_FETCH;
                end
            end
            S_OP_FETCH: state_d = S_ALU_OP;
            S_ALU_OP: begin
                unique case (op_q)
                    OP_ADD:  {carry_d, acc_d} = sum;
                    OP_AND:  acc_d = acc_q & rdata_q;
                    OP_XOR:  acc_d = acc_q ^ rdata_q;
                    OP_LDA:  acc_d = rdata_q;
                    OP_SKZ:  if (acc_q == '0) pc_d = pc_q + ADDR_W'(1);
                    OP_JMP:  pc_d = opnd_q;
                    default: ;
                endcase
                state_d = S_STORE;
            end
            S_STORE: begin
                mem_we  = (op_q == OP_STO);
                cnt_d   = cnt_inc;
                state_d = S_INST_ADDR;
            end
            default: state_d = S_STOPPED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_STOPPED;
            pc_q    <= '0;
            acc_q   <= '0;
            op_q    <= OP_HLT;
            opnd_q  <= '0;
            carry_q <= 1'b0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            carry_q <= carry_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the RAM has no reset so it maps to a plain memory macro; rst only blocks writes.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.halt        = halt_q;
    assign bus.busy        = (state_q != S_STOPPED);
    assign bus.state       = state_q;
    assign bus.pc          = pc_q;
    assign bus.acc         = acc_q;
    assign bus.carry       = carry_q;
    assign bus.instr_count = cnt_q;
endmodule
